instr_serializer: RTL and testbench

Transmit-side counterpart of the instruction decode path. Accepts decoded `instr_type` instructions over a valid/ready interface and buffers them in a small FIFO. Packs each one into its 80-bit wire format, then streams it out as 10 bytes, LSB first, on a byte-wide valid/ready channel. Sits between the host-side instruction generator and the byte link feeding the TPU control unit's instruction receiver.

---
 rtl/instr_serializer_pkg.sv | 41 ++++
 rtl/instr_serializer_fifo.sv | 72 +++++++
 rtl/instr_serializer.sv | 116 +++++++++++
 tb/tb_instr_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_serializer_pkg.sv
// ---------------------------------------------------------------------------
// instr_serializer_pkg
// Shared types for the instruction transmit path: the decoded instruction
// record, its 80-bit wire packing (and the matching unpack), byte type and
// the serializer FSM state encoding.
// ---------------------------------------------------------------------------
package instr_serializer_pkg;

   localparam int INSTR_WIDTH = 80;
   localparam int BYTE_WIDTH  = 8;
   localparam int INSTR_BYTES = INSTR_WIDTH / BYTE_WIDTH;

   typedef logic [BYTE_WIDTH-1:0] byte_type;

   typedef struct packed {
      logic [23:0] buffer_addr;
      logic [15:0] acc_addr;
      logic [31:0] length;
      logic [7:0]  opcode;
   } instr_type;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } serializer_state_type;

   // Wire format: opcode occupies the least significant byte so it leaves first.
   function automatic logic [INSTR_WIDTH-1:0] instr_to_bit(input instr_type instr);
      return {instr.buffer_addr, instr.acc_addr, instr.length, instr.opcode};
   endfunction

   function automatic instr_type bit_to_instr(input logic [INSTR_WIDTH-1:0] bits);
      instr_type r;
      r.buffer_addr = bits[79:56];
      r.acc_addr    = bits[55:40];
      r.length      = bits[39:8];
      r.opcode      = bits[7:0];
      return r;
   endfunction

endpackage

// File: rtl/instr_serializer_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo
// Synchronous FIFO of instr_type entries with occupancy count.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push_i / data_i     write request and entry (ignored when full)
//   pop_i  / data_o     read request and head entry (ignored when empty)
//   count_o             occupancy, 0..FIFO_DEPTH
//   full_o / empty_o    status derived from registered count
// ---------------------------------------------------------------------------
module instr_fifo
   import instr_serializer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  instr_type                     data_i,
   input  logic                          pop_i,
   output instr_type                     data_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o,
   output logic                          full_o,
   output logic                          empty_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   instr_type         mem_q [FIFO_DEPTH];
   instr_type         mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CW'(FIFO_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Full blocks the write even when a pop happens in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = data_i;
      // Pointers wrap naturally because the depth is a power of two.
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/instr_serializer.sv
// ---------------------------------------------------------------------------
// instr_serializer
// Buffers decoded instructions in a small FIFO and streams each one out as
// INSTR_BYTES bytes, LSB first, over a byte-wide valid/ready channel.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   instr_i/instr_valid_i/
//   instr_ready_o                   instruction input handshake
//   byte_o/byte_valid_o/
//   byte_ready_i/byte_last_o        byte output handshake, last marks byte 9
//   busy_o                          FIFO non-empty or an instruction in flight
//   fifo_count_o                    FIFO occupancy
// ---------------------------------------------------------------------------
module instr_serializer
   import instr_serializer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  instr_type                     instr_i,
   input  logic                          instr_valid_i,
   output logic                          instr_ready_o,
   output byte_type                      byte_o,
   output logic                          byte_valid_o,
   input  logic                          byte_ready_i,
   output logic                          byte_last_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam logic [3:0] LAST_IDX = 4'(INSTR_BYTES - 1);

   serializer_state_type      state_q, state_d;
   logic [INSTR_WIDTH-1:0]    shreg_q, shreg_d;
   logic [3:0]                idx_q, idx_d;

   instr_type                 fifo_head;
   logic                      fifo_pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      last_accept;

   instr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (instr_valid_i),
      .data_i  (instr_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .count_o (fifo_count_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign last_accept = (state_q == SEND) && byte_ready_i && (idx_q == LAST_IDX);
   // Pop when idle, or when the final byte leaves so the next instruction
   // follows without a bubble.
   assign fifo_pop    = !fifo_empty && ((state_q == IDLE) || last_accept);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               shreg_d = instr_to_bit(fifo_head);
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (byte_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (!fifo_empty) begin
                     shreg_d = instr_to_bit(fifo_head);
                  end else begin
                     shreg_d = '0;
                     state_d = IDLE;
                  end
               end else begin
                  shreg_d = shreg_q >> BYTE_WIDTH;
                  idx_d   = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: all derived from registered state, none from byte_ready_i.
   always_comb begin
      byte_valid_o  = (state_q == SEND);
      byte_o        = (state_q == SEND) ? shreg_q[BYTE_WIDTH-1:0] : '0;
      byte_last_o   = (state_q == SEND) && (idx_q == LAST_IDX);
      busy_o        = !fifo_empty || (state_q == SEND);
      instr_ready_o = !fifo_full;
   end

endmodule

// File: tb/tb_instr_serializer.sv
module tb_instr_serializer;
   import instr_serializer_pkg::*;

   localparam int FIFO_DEPTH = 4;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   instr_type       instr_i;
   logic            instr_valid_i;
   logic            instr_ready_o;
   byte_type        byte_o;
   logic            byte_valid_o;
   logic            byte_ready_i;
   logic            byte_last_o;
   logic            busy_o;
   logic [CW-1:0]   fifo_count_o;

   instr_serializer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr_i       (instr_i),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .byte_o        (byte_o),
      .byte_valid_o  (byte_valid_o),
      .byte_ready_i  (byte_ready_i),
      .byte_last_o   (byte_last_o),
      .busy_o        (busy_o),
      .fifo_count_o  (fifo_count_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard state: expected {last, byte} stream and original instructions.
   logic [8:0]  exp_q [$];
   instr_type   orig_q [$];
   logic [79:0] asm_bits;
   int          asm_k = 0;
   int          n_bytes_acc = 0;
   logic        stall_prev = 1'b0;
   byte_type    prev_byte = '0;
   logic [8:0]  e;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   // Reference: byte k of an instruction from its fields.
   function automatic byte_type ref_byte(input instr_type in, input int k);
      if (k == 0)      return in.opcode;
      else if (k <= 4) return byte_type'(in.length >> (8 * (k - 1)));
      else if (k <= 6) return byte_type'(in.acc_addr >> (8 * (k - 5)));
      else             return byte_type'(in.buffer_addr >> (8 * (k - 7)));
   endfunction

   function automatic instr_type rand_instr();
      instr_type r;
      r.buffer_addr = 24'($urandom);
      r.acc_addr    = 16'($urandom);
      r.length      = $urandom;
      r.opcode      = 8'($urandom);
      return r;
   endfunction

   // Monitor: inputs only change just after posedge, so the negedge view
   // is exactly what the next posedge will act on.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         orig_q.delete();
         asm_k      = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid_hold", 80'(byte_valid_o), 80'(1));
            chk("stall_byte_hold", 80'(byte_o), 80'(prev_byte));
         end
         if (byte_valid_o && byte_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte_qsize", 80'(exp_q.size()), 80'(1));
            end else begin
               e = exp_q.pop_front();
               chk("byte_value", 80'(byte_o), 80'(e[7:0]));
               chk("byte_last", 80'(byte_last_o), 80'(e[8]));
               if (asm_k < 10) asm_bits[8*asm_k +: 8] = byte_o;
               asm_k++;
               n_bytes_acc++;
               if (e[8]) begin
                  chk("roundtrip", 80'(bit_to_instr(asm_bits)), 80'(orig_q.pop_front()));
                  asm_k = 0;
               end
            end
         end
         if (instr_valid_i && instr_ready_o) begin
            orig_q.push_back(instr_i);
            for (int k = 0; k < 10; k++) exp_q.push_back({k == 9, ref_byte(instr_i, k)});
         end
         stall_prev = byte_valid_o && !byte_ready_i;
         prev_byte  = byte_o;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_instr(input instr_type x, input int max_wait);
      bit acc = 1'b0;
      instr_i       = x;
      instr_valid_i = 1'b1;
      for (int i = 0; i < max_wait && !acc; i++) begin
         @(negedge clk);
         acc = instr_ready_o;
         @(posedge clk);
         #1;
      end
      instr_valid_i = 1'b0;
      chk("push_accepted", 80'(acc), 80'(1));
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (!busy_o && exp_q.size() == 0) break;
      end
      chk("drain_busy", 80'(busy_o), 80'(0));
      chk("drain_scoreboard_empty", 80'(exp_q.size()), 80'(0));
   endtask

   initial begin
      instr_type x;
      int base;
      int sent;
      bit acc;

      rst_n         = 1'b0;
      instr_i       = '0;
      instr_valid_i = 1'b0;
      byte_ready_i  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 80'(byte_valid_o), 80'(0));
      chk("reset_byte", 80'(byte_o), 80'(0));
      chk("reset_last", 80'(byte_last_o), 80'(0));
      chk("reset_busy", 80'(busy_o), 80'(0));
      chk("reset_count", 80'(fifo_count_o), 80'(0));
      chk("reset_ready", 80'(instr_ready_o), 80'(1));
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      byte_ready_i = 1'b1;

      // Single instruction: latency, order, last flag, busy fall.
      x = '{buffer_addr: 24'hABCDEF, acc_addr: 16'h1234, length: 32'h0000_0010, opcode: 8'h21};
      push_instr(x, 5);
      @(negedge clk);
      chk("single_t1_count", 80'(fifo_count_o), 80'(1));
      chk("single_t1_valid", 80'(byte_valid_o), 80'(0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("single_valid", 80'(byte_valid_o), 80'(1));
         chk("single_last", 80'(byte_last_o), 80'(i == 9));
         chk("single_busy", 80'(busy_o), 80'(1));
         if (i == 0) chk("single_first_byte", 80'(byte_o), 80'(8'h21));
         if (i == 9) chk("single_final_byte", 80'(byte_o), 80'(8'hAB));
      end
      @(negedge clk);
      chk("single_busy_fall", 80'(busy_o), 80'(0));
      chk("single_valid_fall", 80'(byte_valid_o), 80'(0));

      // Backpressure with a 1,0,0,1 ready pattern.
      cyc();
      base = n_bytes_acc;
      push_instr(rand_instr(), 5);
      for (int c = 0; c < 60; c++) begin
         byte_ready_i = (c % 4 == 0) || (c % 4 == 3);
         cyc();
      end
      chk("bp_byte_count", 80'(n_bytes_acc - base), 80'(10));
      byte_ready_i = 1'b1;
      wait_drain(50);

      // Fill the FIFO with the output stalled.
      cyc();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) push_instr(rand_instr(), 20);
      @(negedge clk);
      chk("fill_count", 80'(fifo_count_o), 80'(4));
      chk("fill_ready", 80'(instr_ready_o), 80'(0));
      chk("fill_valid_held", 80'(byte_valid_o), 80'(1));
      cyc();
      byte_ready_i = 1'b1;
      wait_drain(200);

      // Back-to-back: 30 bytes without a bubble.
      cyc();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) push_instr(rand_instr(), 20);
      byte_ready_i = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         chk("b2b_valid", 80'(byte_valid_o), 80'(1));
         chk("b2b_last", 80'(byte_last_o), 80'(i % 10 == 0));
      end
      wait_drain(50);

      // Reset after 4 bytes with 2 instructions queued.
      cyc();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) push_instr(rand_instr(), 20);
      base = n_bytes_acc;
      byte_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst_n        = 1'b0;
      byte_ready_i = 1'b0;
      chk("rst_mid_bytes_before", 80'(n_bytes_acc - base), 80'(4));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", 80'(byte_valid_o), 80'(0));
      chk("rst_mid_count", 80'(fifo_count_o), 80'(0));
      chk("rst_mid_busy", 80'(busy_o), 80'(0));
      cyc();
      x = rand_instr();
      push_instr(x, 5);
      acc = 1'b0;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         acc = byte_valid_o;
      end
      chk("rst_new_valid", 80'(acc), 80'(1));
      chk("rst_new_first_byte", 80'(byte_o), 80'(x.opcode));
      byte_ready_i = 1'b1;
      wait_drain(50);

      // Randomized traffic: 1000 instructions with random backpressure.
      cyc();
      sent = 0;
      for (int c = 0; c < 40000 && sent < 1000; c++) begin
         byte_ready_i = ($urandom_range(0, 3) != 0);
         if (!instr_valid_i && ($urandom_range(0, 1) == 1)) begin
            instr_i       = rand_instr();
            instr_valid_i = 1'b1;
         end
         @(negedge clk);
         acc = instr_valid_i && instr_ready_o;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            instr_valid_i = 1'b0;
         end
      end
      instr_valid_i = 1'b0;
      chk("rand_sent", 80'(sent), 80'(1000));
      byte_ready_i = 1'b1;
      wait_drain(200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
